// File: rtl/draw_scheduler.sv
// draw_scheduler: sequences every pixel write for the Connect-Four screen and
// owns the single VGA adapter write port. A token request paints one 4x4 board
// block; a pointer request paints one 4x4 block in the pointer row, first
// erasing the previously drawn pointer block.
//
// Ports
//   clk                 system clock, rising edge
//   resetn              synchronous reset, active-high despite its name
//   tok_req/ack         token draw handshake (req level, ack one-cycle pulse)
//   tok_col/row/player  token operands (player 0 = red, 1 = yellow)
//   ptr_req/ack         pointer move handshake
//   ptr_col/player      pointer operands
//   x, y, colour, plot  adapter write port, zero whenever plot = 0
//   busy                high in every state except IDLE
module draw_scheduler #(
  parameter int unsigned GRID_LENGTH  = 2,
  parameter int unsigned BLOCK_LENGTH = 4,
  parameter int unsigned COLS         = 7,
  parameter int unsigned ROWS         = 6,
  parameter int unsigned BOARD_Y0     = 6
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       tok_req,
  input  logic [2:0] tok_col,
  input  logic [2:0] tok_row,
  input  logic       tok_player,
  output logic       tok_ack,
  input  logic       ptr_req,
  input  logic [2:0] ptr_col,
  input  logic       ptr_player,
  output logic       ptr_ack,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy
);

  localparam int unsigned XW    = 8;
  localparam int unsigned YW    = 7;
  localparam int unsigned CW    = 3;
  localparam int unsigned POSW  = 3;
  localparam int unsigned CNTW  = 4;
  localparam int unsigned PITCH = GRID_LENGTH + BLOCK_LENGTH;

  localparam logic [POSW-1:0] COLS_L   = POSW'(COLS);
  localparam logic [POSW-1:0] ROWS_L   = POSW'(ROWS);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(15);
  localparam logic [YW-1:0]   PTR_Y0   = YW'(1);
  localparam logic [CW-1:0]   RED      = 3'b100;
  localparam logic [CW-1:0]   YELLOW   = 3'b110;
  localparam logic [CW-1:0]   BLACK    = 3'b000;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ERASE = 2'd1,
    S_DRAW  = 2'd2,
    S_ACK   = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [POSW-1:0]   col_q, col_d;
  logic [POSW-1:0]   row_q, row_d;
  logic [CW-1:0]     colour_q, colour_d;
  logic              is_ptr_q, is_ptr_d;
  logic [POSW-1:0]   prev_col_q, prev_col_d;
  logic              ptr_drawn_q, ptr_drawn_d;

  // State register and latched operands
  always_ff @(posedge clk) begin
    if (resetn) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      col_q       <= '0;
      row_q       <= '0;
      colour_q    <= '0;
      is_ptr_q    <= 1'b0;
      prev_col_q  <= '0;
      ptr_drawn_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      col_q       <= col_d;
      row_q       <= row_d;
      colour_q    <= colour_d;
      is_ptr_q    <= is_ptr_d;
      prev_col_q  <= prev_col_d;
      ptr_drawn_q <= ptr_drawn_d;
    end
  end

  // Next-state: arbitration (token first), operand latch, pixel counter
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    col_d       = col_q;
    row_d       = row_q;
    colour_d    = colour_q;
    is_ptr_d    = is_ptr_q;
    prev_col_d  = prev_col_q;
    ptr_drawn_d = ptr_drawn_q;

    unique case (state_q)
      S_IDLE: begin
        if (tok_req) begin
          is_ptr_d = 1'b0;
          col_d    = tok_col;
          row_d    = tok_row;
          colour_d = tok_player ? YELLOW : RED;
          cnt_d    = '0;
          state_d  = (tok_col >= COLS_L || tok_row >= ROWS_L) ? S_ACK : S_DRAW;
        end else if (ptr_req) begin
          is_ptr_d = 1'b1;
          col_d    = ptr_col;
          row_d    = '0;
          colour_d = ptr_player ? YELLOW : RED;
          cnt_d    = '0;
          // Out-of-range pointer skips straight to ACK, leaving pointer history untouched
          if (ptr_col >= COLS_L)  state_d = S_ACK;
          else if (ptr_drawn_q)   state_d = S_ERASE;
          else                    state_d = S_DRAW;
        end
      end
      S_ERASE: begin
        cnt_d = cnt_q + CNTW'(1);
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = S_DRAW;
        end
      end
      S_DRAW: begin
        cnt_d = cnt_q + CNTW'(1);
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = S_ACK;
          if (is_ptr_q) begin
            prev_col_d  = col_q;
            ptr_drawn_d = 1'b1;
          end
        end
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  logic [POSW-1:0] blk_col;
  logic [XW-1:0]   x0;
  logic [YW-1:0]   tok_y0;
  logic [YW-1:0]   y0;

  // Outputs: adapter port decoded from registered state, cnt and operands
  always_comb begin
    plot    = 1'b0;
    x       = '0;
    y       = '0;
    colour  = '0;
    tok_ack = 1'b0;
    ptr_ack = 1'b0;
    busy    = (state_q != S_IDLE);

    // Erase always targets the previous pointer block in the pointer row
    blk_col = (state_q == S_ERASE) ? prev_col_q : col_q;
    x0      = XW'(GRID_LENGTH) + XW'(blk_col) * XW'(PITCH);
    tok_y0  = YW'(BOARD_Y0) + (YW'(ROWS - 1) - YW'(row_q)) * YW'(PITCH);
    y0      = (state_q == S_ERASE || is_ptr_q) ? PTR_Y0 : tok_y0;

    unique case (state_q)
      S_ERASE: begin
        plot   = 1'b1;
        x      = x0 + XW'(cnt_q[1:0]);
        y      = y0 + YW'(cnt_q[3:2]);
        colour = BLACK;
      end
      S_DRAW: begin
        plot   = 1'b1;
        x      = x0 + XW'(cnt_q[1:0]);
        y      = y0 + YW'(cnt_q[3:2]);
        colour = colour_q;
      end
      S_ACK: begin
        tok_ack = ~is_ptr_q;
        ptr_ack = is_ptr_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_draw_scheduler.sv
// tb_draw_scheduler: scoreboard bench for draw_scheduler. Each scenario pushes
// the expected plot stream into a queue, raises its request, and pops/compares
// every plot cycle the DUT produces until the matching ack.
module tb_draw_scheduler;

  logic       clk = 1'b0;
  logic       resetn;
  logic       tok_req, ptr_req;
  logic [2:0] tok_col, tok_row, ptr_col;
  logic       tok_player, ptr_player;
  logic       tok_ack, ptr_ack;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot, busy;

  int checks = 0;
  int errors = 0;

  logic [17:0] exp_q[$];

  draw_scheduler dut (
    .clk(clk), .resetn(resetn),
    .tok_req(tok_req), .tok_col(tok_col), .tok_row(tok_row),
    .tok_player(tok_player), .tok_ack(tok_ack),
    .ptr_req(ptr_req), .ptr_col(ptr_col), .ptr_player(ptr_player),
    .ptr_ack(ptr_ack),
    .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic int col_x0(input int col);
    return 2 + col * 6;
  endfunction

  function automatic int row_y0(input int row);
    return 6 + (5 - row) * 6;
  endfunction

  // Expected raster order: px fastest, then py
  task automatic push_block(input int xb, input int yb, input logic [2:0] c);
    for (int py = 0; py < 4; py++)
      for (int px = 0; px < 4; px++)
        exp_q.push_back({8'(xb + px), 7'(yb + py), c});
  endtask

  // Runs one transaction to its ack, comparing plots against the scoreboard
  task automatic collect(input bit want_ptr, input int ack_at, input string name);
    bit          done = 1'b0;
    logic [17:0] e;
    for (int i = 1; i <= ack_at + 4 && !done; i++) begin
      @(negedge clk);
      if (plot) begin
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL %s busy during plot cycle %0d: got %b want 1", name, i, busy);
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL %s unexpected plot cycle %0d at (%0d,%0d) c=%b", name, i, x, y, colour);
        end else begin
          e = exp_q.pop_front();
          if ({x, y, colour} !== e)
          begin
            errors++;
            $display("FAIL %s plot %0d: got (%0d,%0d,%b) want (%0d,%0d,%b)",
                     name, i, x, y, colour, e[17:10], e[9:3], e[2:0]);
          end
        end
      end else begin
        checks++;
        if ({x, y, colour} !== 18'd0) begin
          errors++;
          $display("FAIL %s port not zero without plot, cycle %0d: got (%0d,%0d,%b)", name, i, x, y, colour);
        end
      end
      checks++;
      if (tok_ack === 1'b1 && ptr_ack === 1'b1) begin
        errors++;
        $display("FAIL %s both acks high at cycle %0d", name, i);
      end
      if (tok_ack === 1'b1 || ptr_ack === 1'b1) begin
        done = 1'b1;
        checks++;
        if (ptr_ack !== want_ptr || tok_ack !== !want_ptr) begin
          errors++;
          $display("FAIL %s ack kind: got tok=%b ptr=%b want ptr=%b", name, tok_ack, ptr_ack, want_ptr);
        end
        checks++;
        if (i != ack_at) begin
          errors++;
          $display("FAIL %s ack cycle: got %0d want %0d", name, i, ack_at);
        end
        checks++;
        if (exp_q.size() != 0) begin
          errors++;
          $display("FAIL %s missing plots at ack: got %0d left want 0", name, exp_q.size());
        end
        if (want_ptr) ptr_req = 1'b0;
        else          tok_req = 1'b0;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s no ack within %0d cycles", name, ack_at + 4);
      tok_req = 1'b0;
      ptr_req = 1'b0;
    end
    exp_q.delete();
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || tok_ack !== 1'b0 || ptr_ack !== 1'b0 || plot !== 1'b0) begin
      errors++;
      $display("FAIL %s post-ack idle: got busy=%b tok_ack=%b ptr_ack=%b plot=%b want 0",
               name, busy, tok_ack, ptr_ack, plot);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b1;
    tok_req = 1'b0; ptr_req = 1'b0;
    tok_col = '0; tok_row = '0; ptr_col = '0;
    tok_player = 1'b0; ptr_player = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({plot, busy, tok_ack, ptr_ack, x, y, colour} !== 22'd0) begin
      errors++;
      $display("FAIL reset outputs: got plot=%b busy=%b acks=%b%b x=%0d y=%0d c=%b want all 0",
               plot, busy, tok_ack, ptr_ack, x, y, colour);
    end
    resetn = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset release busy: got %b want 0", busy);
    end
  endtask

  task automatic run_token(input int col, input int row, input bit pl, input string name);
    bit in_range = (col < 7) && (row < 6);
    if (in_range) push_block(col_x0(col), row_y0(row), pl ? 3'b110 : 3'b100);
    tok_col = 3'(col); tok_row = 3'(row); tok_player = pl;
    tok_req = 1'b1;
    collect(1'b0, in_range ? 17 : 1, name);
  endtask

  task automatic test_token();
    run_token(0, 0, 1'b0, "tok_c0_r0");
    run_token(6, 5, 1'b1, "tok_c6_r5");
    run_token(3, 2, 1'b0, "tok_c3_r2");
  endtask

  task automatic test_pointer();
    // First pointer after reset: no erase
    push_block(20, 1, 3'b110);
    ptr_col = 3'd3; ptr_player = 1'b1; ptr_req = 1'b1;
    collect(1'b1, 17, "ptr_first_c3");
    // Move: erase col3 then draw col4
    push_block(20, 1, 3'b000);
    push_block(26, 1, 3'b110);
    ptr_col = 3'd4; ptr_req = 1'b1;
    collect(1'b1, 33, "ptr_move_c4");
  endtask

  task automatic test_back_to_back();
    push_block(col_x0(1), row_y0(1), 3'b110);
    tok_col = 3'd1; tok_row = 3'd1; tok_player = 1'b1; tok_req = 1'b1;
    ptr_col = 3'd5; ptr_player = 1'b0; ptr_req = 1'b1;
    collect(1'b0, 17, "both_tok_first");
    push_block(26, 1, 3'b000);
    push_block(32, 1, 3'b100);
    collect(1'b1, 33, "both_ptr_second");
  endtask

  task automatic test_out_of_range();
    run_token(7, 0, 1'b0, "tok_col7");
    run_token(0, 6, 1'b1, "tok_row6");
    run_token(2, 7, 1'b0, "tok_row7");
    ptr_col = 3'd7; ptr_player = 1'b1; ptr_req = 1'b1;
    collect(1'b1, 1, "ptr_col7");
    // prev_col must still be 5
    push_block(32, 1, 3'b000);
    push_block(14, 1, 3'b100);
    ptr_col = 3'd2; ptr_player = 1'b0; ptr_req = 1'b1;
    collect(1'b1, 33, "ptr_after_oor");
  endtask

  task automatic test_reset_abort();
    tok_col = 3'd2; tok_row = 3'd3; tok_player = 1'b1; tok_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if ({plot, x, y, colour} !== {1'b1, 8'(14 + i % 4), 7'(18 + i / 4), 3'b110}) begin
        errors++;
        $display("FAIL abort pre-reset plot %0d: got p=%b (%0d,%0d,%b) want (%0d,%0d,110)",
                 i, plot, x, y, colour, 14 + i % 4, 18 + i / 4);
      end
    end
    resetn = 1'b1;
    tok_req = 1'b0;
    @(negedge clk);
    checks++;
    if (plot !== 1'b0 || busy !== 1'b0 || tok_ack !== 1'b0) begin
      errors++;
      $display("FAIL abort after reset: got plot=%b busy=%b tok_ack=%b want 0", plot, busy, tok_ack);
    end
    resetn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (tok_ack !== 1'b0 || ptr_ack !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL abort spurious ack/busy: got tok=%b ptr=%b busy=%b want 0", tok_ack, ptr_ack, busy);
      end
    end
    // Reset cleared pointer history: no erase
    push_block(2, 1, 3'b110);
    ptr_col = 3'd0; ptr_player = 1'b1; ptr_req = 1'b1;
    collect(1'b1, 17, "ptr_after_abort");
  endtask

  initial begin
    test_reset();
    test_token();
    test_pointer();
    test_back_to_back();
    test_out_of_range();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
